// File: rtl/spi_pkg.sv
// Shared types and sizing for the SPI master transceiver.
package spi_pkg;

    localparam int DATA_W  = 32;
    localparam int WIDTH_W = 5;
    localparam int NUM_SS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: a down-counter that ticks once every HALF_DIV cycles while
// enabled and sits at its reload value while disabled.
module spi_clk_div #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = RELOAD;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q == '0) begin
                tick = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_transceiver.sv
// Full-duplex SPI master: one start strobe shifts width+1 bits MSB-first out of
// mosi while collecting miso, then presents the received word with a valid pulse.
//
// state | meaning
// IDLE  | waiting for spi_en_in; slave selects released
// LEAD  | selects asserted, one half-period before the first sclk edge
// XFER  | 2*(width+1) sclk edges, sample/shift per CPHA
// TRAIL | sclk back at CPOL, one half-period before release
module spi_transceiver
    import spi_pkg::*;
#(
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0,
    parameter int HALF_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_en_in,
    input  logic [NUM_SS-1:0]  ss_in,
    output logic [NUM_SS-1:0]  ss_out,
    input  logic [WIDTH_W-1:0] width,
    output logic               mosi,
    input  logic               miso,
    output logic               sclk_out,
    input  logic [DATA_W-1:0]  din,
    output logic [DATA_W-1:0]  dout,
    output logic               dval_out,
    output logic               idle_out
);

    localparam int ECNT_W = WIDTH_W + 2;

    spi_state_e state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [ECNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [NUM_SS-1:0] ss_q, ss_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              dval_q, dval_d;

    logic              tick;
    logic              edge_now;
    logic              sample_edge;
    logic [DATA_W-1:0] tx_aligned;

    spi_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    // Left-align the word so the current bit is always tx_q[MSB].
    assign tx_aligned = din << (WIDTH_W'(DATA_W - 1) - width);

    // Remaining-edge count is even on leading edges since it starts at 2*(width+1).
    assign sample_edge = (~edge_cnt_q[0]) ^ CPHA;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        dout_d     = dout_q;
        edge_cnt_d = edge_cnt_q;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        dval_d     = 1'b0;
        edge_now   = 1'b0;

        case (state_q)
            IDLE: begin
                if (spi_en_in) begin
                    state_d    = LEAD;
                    ss_d       = ~ss_in;
                    rx_d       = '0;
                    edge_cnt_d = {1'b0, width, 1'b0} + ECNT_W'(2);
                    if (!CPHA) begin
                        mosi_d = tx_aligned[DATA_W-1];
                        tx_d   = tx_aligned << 1;
                    end else begin
                        tx_d   = tx_aligned;
                    end
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d  = XFER;
                    edge_now = 1'b1;
                end
            end
            XFER: begin
                if (tick) begin
                    if (edge_cnt_q != '0) begin
                        edge_now = 1'b1;
                    end else begin
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    state_d = IDLE;
                    ss_d    = '1;
                    dout_d  = rx_q;
                    dval_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (edge_now) begin
            sclk_d     = ~sclk_q;
            edge_cnt_d = edge_cnt_q - ECNT_W'(1);
            if (sample_edge) begin
                rx_d = {rx_q[DATA_W-2:0], miso};
            end else if (edge_cnt_q != ECNT_W'(1)) begin
                mosi_d = tx_q[DATA_W-1];
                tx_d   = tx_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            dout_q     <= '0;
            edge_cnt_q <= '0;
            ss_q       <= '1;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            dval_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            dout_q     <= dout_d;
            edge_cnt_q <= edge_cnt_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            dval_q     <= dval_d;
        end
    end

    assign ss_out   = ss_q;
    assign mosi     = mosi_q;
    assign sclk_out = sclk_q;
    assign dout     = dout_q;
    assign dval_out = dval_q;
    assign idle_out = (state_q == IDLE);

endmodule

// File: tb/tb_spi_transceiver.sv
// Four cross-wired transceiver pairs, one per CPOL/CPHA mode, driven by common
// stimulus; received words are checked against a queue of expected words.
module tb_spi_transceiver;

    localparam int HD = 2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [4:0]  width;
    logic [31:0] dina, dinb;
    logic [3:0]  ssa, ssb;

    logic [3:0]  ss_o   [8];
    logic        mosi_o [8];
    logic        sclk_o [8];
    logic [31:0] dout_o [8];
    logic        dval_o [8];
    logic        idle_o [8];

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   dval_seen = 0;
    int   exp_dvals = 0;

    for (genvar c = 0; c < 4; c++) begin : g_pair
        spi_transceiver #(
            .CPOL     (bit'(c / 2)),
            .CPHA     (bit'(c % 2)),
            .HALF_DIV (HD)
        ) u_a (
            .clk       (clk),
            .rst       (rst),
            .spi_en_in (en),
            .ss_in     (ssa),
            .ss_out    (ss_o[2*c]),
            .width     (width),
            .mosi      (mosi_o[2*c]),
            .miso      (mosi_o[2*c+1]),
            .sclk_out  (sclk_o[2*c]),
            .din       (dina),
            .dout      (dout_o[2*c]),
            .dval_out  (dval_o[2*c]),
            .idle_out  (idle_o[2*c])
        );
        spi_transceiver #(
            .CPOL     (bit'(c / 2)),
            .CPHA     (bit'(c % 2)),
            .HALF_DIV (HD)
        ) u_b (
            .clk       (clk),
            .rst       (rst),
            .spi_en_in (en),
            .ss_in     (ssb),
            .ss_out    (ss_o[2*c+1]),
            .width     (width),
            .mosi      (mosi_o[2*c+1]),
            .miso      (mosi_o[2*c]),
            .sclk_out  (sclk_o[2*c+1]),
            .din       (dinb),
            .dout      (dout_o[2*c+1]),
            .dval_out  (dval_o[2*c+1]),
            .idle_out  (idle_o[2*c+1])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask_w(input logic [31:0] d, input logic [4:0] w);
        logic [32:0] m;
        m = (33'd1 << (int'(w) + 1)) - 33'd1;
        return d & m[31:0];
    endfunction

    function automatic logic cpol_of(input int i);
        return (i >= 4);
    endfunction

    task automatic check_reset_vals();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rst_sclk%0d", i), 32'(sclk_o[i]), 32'(cpol_of(i)));
            chk($sformatf("rst_mosi%0d", i), 32'(mosi_o[i]), 32'd0);
            chk($sformatf("rst_ss%0d", i),   32'(ss_o[i]),   32'hF);
            chk($sformatf("rst_dout%0d", i), dout_o[i],      32'd0);
            chk($sformatf("rst_dval%0d", i), 32'(dval_o[i]), 32'd0);
            chk($sformatf("rst_idle%0d", i), 32'(idle_o[i]), 32'd1);
        end
    endtask

    // Every completion must be one common pulse carrying the partner's word.
    always @(negedge clk) begin
        automatic bit   any = 1'b0;
        automatic exp_t e;
        for (int i = 0; i < 8; i++) any |= dval_o[i];
        if (any) begin
            dval_seen++;
            if (exp_q.size() == 0) begin
                chk("dval_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < 8; i++) begin
                    chk($sformatf("dval_all%0d", i), 32'(dval_o[i]), 32'd1);
                    chk($sformatf("idle_w_dval%0d", i), 32'(idle_o[i]), 32'd1);
                    chk($sformatf("dout%0d", i), dout_o[i], (i % 2 == 0) ? e.a : e.b);
                end
            end
        end
    end

    // Starts a transfer in the current cycle; p1/p2 add ignored start pulses,
    // abort_at pulls reset low at that busy cycle.
    task automatic xfer(input logic [31:0] a, input logic [31:0] b, input logic [4:0] w,
                        input logic [3:0] sa, input logic [3:0] sb,
                        input int p1, input int p2, input int abort_at);
        int   busy;
        int   edges [8];
        logic prev  [8];
        logic [3:0] ss_exp;
        bit   ss_bad;
        bit   aborted;
        exp_t dummy;
        dina = a; dinb = b; width = w; ssa = sa; ssb = sb; en = 1'b1;
        exp_q.push_back('{a: mask_w(b, w), b: mask_w(a, w)});
        exp_dvals++;
        for (int i = 0; i < 8; i++) begin
            prev[i]  = sclk_o[i];
            edges[i] = 0;
        end
        busy = 0; ss_bad = 1'b0; aborted = 1'b0;
        @(negedge clk);
        while (!idle_o[0] && busy < 1000) begin
            busy++;
            en = (busy == p1 || busy == p2);
            if (busy == 5) begin
                dina = $urandom; dinb = $urandom; width = 5'($urandom);
                ssa = 4'($urandom); ssb = 4'($urandom);
            end
            for (int i = 0; i < 8; i++) begin
                ss_exp = (i % 2 == 0) ? ~sa : ~sb;
                if (ss_o[i] !== ss_exp) ss_bad = 1'b1;
                if (sclk_o[i] !== prev[i]) edges[i]++;
                prev[i] = sclk_o[i];
            end
            if (busy == abort_at) begin
                rst = 1'b0;
                #1;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        en = 1'b0;
        if (aborted) begin
            dummy = exp_q.pop_back();
            exp_dvals--;
            check_reset_vals();
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
        end else begin
            chk("busy_cycles", 32'(busy), 32'(2 * HD * (int'(w) + 2)));
            chk("ss_during_xfer", 32'(ss_bad), 32'd0);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("sclk_edges%0d", i), 32'(edges[i]), 32'(2 * (int'(w) + 1)));
                chk($sformatf("sclk_idle%0d", i), 32'(sclk_o[i]), 32'(cpol_of(i)));
                chk($sformatf("ss_idle%0d", i), 32'(ss_o[i]), 32'hF);
            end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; width = '0; dina = '0; dinb = '0; ssa = '0; ssb = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b1;
        @(negedge clk);

        xfer(32'hAA0F3366, 32'h55F0CC99, 5'd31, 4'b0001, 4'b0010, 0, 0, 0);
        @(negedge clk);
        xfer(32'h12345678, 32'h9ABCDEF0, 5'd31, 4'b0101, 4'b0101, 42, 124, 0);
        xfer(32'hDEADBEEF, 32'h0BADF00D, 5'd31, 4'b0000, 4'b1000, 0, 0, 0);
        xfer(32'hAA0F3366, 32'h55F0CC99, 5'd7, 4'b0011, 4'b1100, 0, 0, 0);
        xfer(32'h00000001, 32'h00000000, 5'd0, 4'b0001, 4'b0001, 0, 0, 0);
        xfer(32'hFFFFFFFE, 32'hFFFFFFFF, 5'd0, 4'b0001, 4'b0001, 0, 0, 0);
        repeat (4) xfer($urandom, $urandom, 5'($urandom), 4'($urandom), 4'($urandom), 0, 0, 0);
        xfer(32'hCAFEF00D, 32'h13579BDF, 5'd31, 4'b1111, 4'b1111, 0, 0, 50);
        xfer(32'hAA0F3366, 32'h55F0CC99, 5'd31, 4'b0001, 4'b0001, 0, 0, 0);
        repeat (4) @(negedge clk);

        chk("dval_count", 32'(dval_seen), 32'(exp_dvals));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_transceiver.md
# spi_transceiver

Single-channel SPI master transceiver: on a start pulse it asserts selected slave-select lines, shifts out `din` MSB-first on `mosi` while sampling `miso`, and presents the received word on `dout` with a one-cycle valid strobe. The block sits between register-mapped control logic and external SPI pins. It is full-duplex, so two instances can be cross-wired (`mosi`↔`miso`) for loopback.

## Interface
- `CPOL`, 0: idle level of `sclk_out`.
- `CPHA`, 0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing.
- `HALF_DIV`, 2: `clk` cycles per sclk half-period (≥1).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `spi_en_in` in 1: start strobe, sampled only while idle.
- `ss_in` in 4: slave mask; bit i=1 selects slave i.
- `ss_out` out 4: active-low slave selects.
- `width` in 5: bits per transfer minus 1 (31 = 32 bits).
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.
- `sclk_out` out 1: SPI clock.
- `din` in 32: transmit word, right-aligned in `din[width:0]`.
- `dout` out 32: received word, right-aligned, upper bits zero.
- `dval_out` out 1: one-cycle pulse when `dout` updates.
- `idle_out` out 1: high when no transfer is in progress.

## Operation
- Reset values: `sclk_out`=CPOL, `mosi`=0, `ss_out`=4'hF, `dout`=0, `dval_out`=0, `idle_out`=1, state IDLE.
- States: IDLE → LEAD → XFER → TRAIL → IDLE.
- IDLE: when `spi_en_in`=1 at a clock edge, latch `din`, `width` and `ss_in`, then go to LEAD. `spi_en_in` is ignored in every other state; a start is never queued.
- LEAD, one half-period: `ss_out` = ~latched mask. With CPHA=0, `mosi` = latched `din[width]`.
- XFER: 2·(width+1) sclk edges. `sclk_out` toggles every HALF_DIV cycles, and the first edge is the leading edge.
  - Sample edge: shift `miso` into the receive register LSB, so bits arrive MSB-first.
  - Shift edge: drive the next lower transmit bit. With CPHA=1 the first leading edge drives `din[width]`.
  - There is no shift after the last sample.
- TRAIL, one half-period: `sclk_out`=CPOL and `mosi` holds its last value.
- Return to IDLE:
  - `ss_out`=4'hF and `idle_out`=1.
  - `dout` = received bits zero-extended.
  - `dval_out`=1 for exactly one cycle.
  - `dout` holds until the next completion.
- ss_in=0: the transfer runs normally with all `ss_out` lines high.
- Changing `din`, `width` or `ss_in` mid-transfer has no effect.
- Reset mid-transfer aborts immediately to reset values, with no `dval_out` pulse.

## Timing
- `spi_en_in` sampled high at edge N:
  - `idle_out` falls and `ss_out` asserts after edge N.
  - The first sclk edge occurs HALF_DIV cycles later.
- Busy duration = HALF_DIV·(2·(width+1)+2) cycles. Example: width=31, HALF_DIV=2 gives 132 cycles.
- `dval_out` and `idle_out` rise in the same cycle.
- A start is accepted in the cycle `idle_out`=1, so back-to-back transfers are possible.
- `width`=0 transfers one bit. All 5-bit values are legal.

## Structure
- Package `spi_pkg`: state enum (IDLE, LEAD, XFER, TRAIL), data width constant 32, width-field size 5, slave count 4.
- Sub-module `spi_clk_div`: half-period counter emitting a tick every HALF_DIV cycles, enabled only outside IDLE.
- Top holds the FSM, the transmit/receive shift registers, the edge counter and the registered outputs.

## Test plan
- Loopback, two instances cross-wired, CPOL=CPHA=0, width=31, dina=AA0F3366, dinb=55F0CC99, common one-cycle `spi_en_in` → after 132 cycles `douta`=55F0CC99, `doutb`=AA0F3366, both `dval_out` pulse once, `idle_out`=1.
- Starts while busy: pulses at 0, +42 and +124 cycles after the first → exactly one transfer and one `dval_out`. A pulse at +132 starts a second transfer.
- width=7 with the same data → `doutb`=00000066, `douta`=00000099, busy 36 cycles.
- All four CPOL/CPHA combinations in loopback → data correct, `sclk_out` idles at CPOL, exactly 64 sclk edges for width=31.
- ss_in=4'b0101 → `ss_out`=4'b1010 during the transfer and 4'hF otherwise. ss_in=0 → `ss_out` stays 4'hF and data still transfers.
- `rst` low mid-transfer → outputs at reset values at once, no `dval_out`. A new start after release works normally.
